alu_share_arbiter: RTL
======================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one single-cycle ALU datapath between N_REQ requesters, e.g. the execute stage and the branch/address unit.
//  Requests are arbitrated round-robin with valid/ready handshakes.
//  The winning operand set is driven into the ALU, and the result is registered into a one-entry output slot.
//  The slot's response carries the requester ID and is backpressured by rsp_ready.
// PARAMETERS
//  N_REQ    2   number of requesters, 2..8
//  ID_W     1   width of rsp_id; must satisfy 2**ID_W >= N_REQ
// PORTS
//  clk        in   1         rising-edge clock
//  rst_n      in   1         asynchronous, active-low reset
//  req_valid  in   N_REQ     request i present
//  req_ready  out  N_REQ     request i accepted this cycle (one-hot or zero)
//  req_a      in   N_REQ*32  operand A, slice i = [32*i+:32]
//  req_b      in   N_REQ*32  operand B
//  req_shamt  in   N_REQ*5   immediate shift amount
//  req_sub    in   N_REQ     sub/sra select
//  req_func   in   N_REQ*4   ALU function code
//  rsp_valid  out  1         output slot holds a result
//  rsp_ready  in   1         consumer takes the result
//  rsp_id     out  ID_W      index of the requester that produced rsp_data
//  rsp_data   out  32        ALU result
// BEHAVIOUR
//  - Reset: rsp_valid=0, rsp_id=0, rsp_data=0, rr_ptr=0; req_ready=0 while rst_n low.
//  - slot_free = !rsp_valid | rsp_ready.
//  - When slot_free, grant the first valid requester at or after rr_ptr (cyclic search).
//    req_ready = that one-hot grant, combinational.
//  - Accept on req_valid[i] & req_ready[i]:
//    - rsp_data <= ALU(grant operands); rsp_id <= i; rsp_valid <= 1.
//    - rr_ptr <= (i==N_REQ-1) ? 0 : i+1.
//  - No accept and rsp_ready: rsp_valid <= 0; rsp_data/rsp_id hold their last value.
//  - Latency: result visible the cycle after acceptance. Throughput is one op/cycle while rsp_ready=1.
//  - rsp_valid=1 & rsp_ready=1 with a new accept in the same cycle: the slot is replaced, no bubble.
//  - rsp_valid=1 & rsp_ready=0: req_ready=0 for all; rsp_data and rsp_id stay stable.
//  - Requester rules: payload stable while req_valid & !req_ready. A requester must not drop req_valid before it is accepted.
//  - rr_ptr moves only on accept. Idle cycles never change priority.
//  - Function codes (unsigned 32-bit wrap, shifts use B[4:0]):
//    - 0 add/sub, 1 xor, 2 or, 3 and, 4 sll shamt, 5 sll B.
//    - 6 srl/sra B, 7 srl/sra shamt, 8 slt, 9 sltu.
//    - codes 10..15 produce 0, which is a legal response, not an error.
//  - Async reset mid-operation discards the slot and any in-flight grant. No response is produced for it.
// CONFIGURATION
//  ALU_ARB_STATS_EN defined:
//    - adds out port stall_cnt (N_REQ*16).
//    - Counter i increments each cycle req_valid[i] & !req_ready[i], saturates at 16'hFFFF, and resets to 0.
//  Not defined: port and counters absent; behaviour otherwise identical.
// STRUCTURE
//  - Shared package alu_pkg holds:
//    - the ALU_FUNC_* localparams (4'd0..4'd9).
//    - ALU_W=32 and SHAMT_W=5.
//    - the stats counter width.
//  - Sub-module rr_arbiter (N_REQ): inputs req vector, rr_ptr, enable; output one-hot grant.
//  - The existing ALU datapath is instantiated once on the muxed operands.
// TESTING
//  1. Reset mid-traffic: drop rst_n while rsp_valid=1 -> rsp_valid=0, rsp_data=0, rr_ptr=0 immediately; no stale response.
//  2. Single requester: req0 a=5 b=3 func=0 sub=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_data=2.
//  3. Fairness: both valid for 4 cycles, rsp_ready=1 -> grants 0,1,0,1 with no idle bubbles.
//  4. Backpressure: rsp_ready=0 with slot full, req1 func=8 a=-1 b=1 pending:
//     - rsp_data held and req_ready=0 across 3 cycles.
//     - after rsp_ready rises, rsp_data=1 (slt), rsp_id=1.
//  5. Wrap and shifts, N_REQ=3, ptr=2:
//     - req2 func=6 sub=1 a=32'h8000_0000 b=4 -> 32'hF800_0000.
//     - ptr then wraps to 0, and a pending req0 is granted next.
//  6. Illegal func=4'hB -> rsp_data=0.
//     With ALU_ARB_STATS_EN: a starved requester's stall_cnt equals its waiting cycle count exactly.

Source files
------------

// File: rtl/alu_share_arbiter_pkg.sv
// Shared ALU definitions: widths, function codes and the single-cycle ALU datapath.
// Read by alu_share_arbiter, its interface and the optional ALU_ARB_STATS_EN stall counters.
package alu_pkg;

  localparam int ALU_W   = 32;
  localparam int SHAMT_W = 5;
  localparam int FUNC_W  = 4;
  localparam int STAT_W  = 16;

  localparam logic [FUNC_W-1:0] ALU_FUNC_ADD   = 4'd0;
  localparam logic [FUNC_W-1:0] ALU_FUNC_XOR   = 4'd1;
  localparam logic [FUNC_W-1:0] ALU_FUNC_OR    = 4'd2;
  localparam logic [FUNC_W-1:0] ALU_FUNC_AND   = 4'd3;
  localparam logic [FUNC_W-1:0] ALU_FUNC_SLLI  = 4'd4;
  localparam logic [FUNC_W-1:0] ALU_FUNC_SLL   = 4'd5;
  localparam logic [FUNC_W-1:0] ALU_FUNC_SRL   = 4'd6;
  localparam logic [FUNC_W-1:0] ALU_FUNC_SRLI  = 4'd7;
  localparam logic [FUNC_W-1:0] ALU_FUNC_SLT   = 4'd8;
  localparam logic [FUNC_W-1:0] ALU_FUNC_SLTU  = 4'd9;

  // Unused codes return zero; "sub" selects subtract for ADD and arithmetic shift for SRL*.
  function automatic logic [ALU_W-1:0] alu_compute(
    input logic [FUNC_W-1:0]  func,
    input logic [ALU_W-1:0]   a,
    input logic [ALU_W-1:0]   b,
    input logic [SHAMT_W-1:0] shamt,
    input logic               sub
  );
    logic [ALU_W-1:0] r;
    case (func)
      ALU_FUNC_ADD:  r = sub ? (a - b) : (a + b);
      ALU_FUNC_XOR:  r = a ^ b;
      ALU_FUNC_OR:   r = a | b;
      ALU_FUNC_AND:  r = a & b;
      ALU_FUNC_SLLI: r = a << shamt;
      ALU_FUNC_SLL:  r = a << b[SHAMT_W-1:0];
      ALU_FUNC_SRL:  r = sub ? $unsigned($signed(a) >>> b[SHAMT_W-1:0]) : (a >> b[SHAMT_W-1:0]);
      ALU_FUNC_SRLI: r = sub ? $unsigned($signed(a) >>> shamt) : (a >> shamt);
      ALU_FUNC_SLT:  r = {{(ALU_W-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_FUNC_SLTU: r = {{(ALU_W-1){1'b0}}, (a < b)};
      default:       r = {ALU_W{1'b0}};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the ALU requesters and alu_share_arbiter.
interface alu_share_arbiter_if
  import alu_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int ID_W  = 1
);

  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ-1:0]         req_ready;
  logic [N_REQ*ALU_W-1:0]   req_a;
  logic [N_REQ*ALU_W-1:0]   req_b;
  logic [N_REQ*SHAMT_W-1:0] req_shamt;
  logic [N_REQ-1:0]         req_sub;
  logic [N_REQ*FUNC_W-1:0]  req_func;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [ALU_W-1:0]         rsp_data;

  modport master (
    output req_valid, req_a, req_b, req_shamt, req_sub, req_func, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_a, req_b, req_shamt, req_sub, req_func, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );

endinterface

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr_i, cyclically.
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int ID_W  = 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  input  logic             en_i,
  output logic [N_REQ-1:0] grant_o
);

  // Cyclic priority search starting at the pointer.
  always_comb begin
    logic found;
    int   idx;
    grant_o = {N_REQ{1'b0}};
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end else begin
        idx = idx;
      end
      if (en_i && !found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU among N_REQ requesters with round-robin arbitration and a one-entry result slot.
// Optional ALU_ARB_STATS_EN adds per-requester saturating stall counters on port stall_cnt.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int ID_W  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  alu_share_arbiter_if.slave      bus
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [N_REQ*STAT_W-1:0] stall_cnt
`endif
);

  logic                  slot_free_s;
  logic                  accept_s;
  logic [N_REQ-1:0]      grant_s;
  logic [ID_W-1:0]       gnt_id_s;
  logic [ALU_W-1:0]      op_a_s;
  logic [ALU_W-1:0]      op_b_s;
  logic [SHAMT_W-1:0]    op_shamt_s;
  logic                  op_sub_s;
  logic [FUNC_W-1:0]     op_func_s;
  logic [ALU_W-1:0]      alu_res_s;

  logic                  rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]       rsp_id_q, rsp_id_d;
  logic [ALU_W-1:0]      rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;

  assign slot_free_s   = !rsp_valid_q || bus.rsp_ready;
  assign bus.req_ready = grant_s & {N_REQ{rst_n}};
  assign accept_s      = |bus.req_ready;

  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_rr_arbiter (
    .req_i   (bus.req_valid),
    .ptr_i   (rr_ptr_q),
    .en_i    (slot_free_s),
    .grant_o (grant_s)
  );

  // Operand mux driven by the one-hot grant.
  always_comb begin
    op_a_s     = {ALU_W{1'b0}};
    op_b_s     = {ALU_W{1'b0}};
    op_shamt_s = {SHAMT_W{1'b0}};
    op_sub_s   = 1'b0;
    op_func_s  = {FUNC_W{1'b0}};
    gnt_id_s   = {ID_W{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_s[i]) begin
        op_a_s     = bus.req_a[ALU_W*i +: ALU_W];
        op_b_s     = bus.req_b[ALU_W*i +: ALU_W];
        op_shamt_s = bus.req_shamt[SHAMT_W*i +: SHAMT_W];
        op_sub_s   = bus.req_sub[i];
        op_func_s  = bus.req_func[FUNC_W*i +: FUNC_W];
        gnt_id_s   = ID_W'(i);
      end else begin
        gnt_id_s = gnt_id_s;
      end
    end
  end

  assign alu_res_s = alu_compute(op_func_s, op_a_s, op_b_s, op_shamt_s, op_sub_s);

  // Slot and pointer next state; id/data hold when the slot drains without a replacement.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rr_ptr_d    = rr_ptr_q;
    if (accept_s) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = gnt_id_s;
      rsp_data_d  = alu_res_s;
      rr_ptr_d    = (gnt_id_s == ID_W'(N_REQ - 1)) ? {ID_W{1'b0}} : (gnt_id_s + ID_W'(1));
    end else if (bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end else begin
      rsp_valid_d = rsp_valid_q;
    end
  end

  // Slot and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= {ID_W{1'b0}};
      rsp_data_q  <= {ALU_W{1'b0}};
      rr_ptr_q    <= {ID_W{1'b0}};
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;

`ifdef ALU_ARB_STATS_EN
  logic [STAT_W-1:0] stall_q [N_REQ];
  logic [STAT_W-1:0] stall_d [N_REQ];

  // Saturating count of cycles each requester waits unserved.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      stall_d[i] = stall_q[i];
      if (bus.req_valid[i] && !bus.req_ready[i] && (stall_q[i] != {STAT_W{1'b1}})) begin
        stall_d[i] = stall_q[i] + STAT_W'(1);
      end else begin
        stall_d[i] = stall_q[i];
      end
    end
  end

  // Stall counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REQ; i++) begin
        stall_q[i] <= {STAT_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        stall_q[i] <= stall_d[i];
      end
    end
  end

  // Flatten counters onto the output port.
  always_comb begin
    stall_cnt = {(N_REQ*STAT_W){1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      stall_cnt[STAT_W*i +: STAT_W] = stall_q[i];
    end
  end
`endif

endmodule
